// File: rtl/gol_pkg.sv
// Shared types for the Game-of-Life generation engine: FSM states,
// neighbour-count type and the per-cell birth/survival rule.
package gol_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_SWAP
  } gen_state_e;

  typedef logic [3:0] nbr_count_t;

  function automatic logic life_rule(input logic alive, input nbr_count_t n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/row_next_state.sv
// Combinational next-state of one full row from a top/mid/bot window.
// Build option: GOL_TORUS_WRAP_EN wraps columns; otherwise out-of-range columns are dead.
module row_next_state
  import gol_pkg::*;
#(
  parameter int X_SIZE  = 1280,
  parameter int X_WIDTH = 11
) (
  input  logic [X_SIZE-1:0] top,
  input  logic [X_SIZE-1:0] mid,
  input  logic [X_SIZE-1:0] bot,
  output logic [X_SIZE-1:0] next_row
);

`ifdef GOL_TORUS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  for (genvar c = 0; c < X_SIZE; c++) begin : g_col
    localparam logic [X_WIDTH-1:0] CL = (c == 0) ? X_WIDTH'(X_SIZE - 1) : X_WIDTH'(c - 1);
    localparam logic [X_WIDTH-1:0] CC = X_WIDTH'(c);
    localparam logic [X_WIDTH-1:0] CR = (c == X_SIZE - 1) ? '0 : X_WIDTH'(c + 1);
    // Edge columns only see their off-grid neighbours when the grid wraps.
    localparam bit L_OK = WRAP || (c != 0);
    localparam bit R_OK = WRAP || (c != X_SIZE - 1);

    logic [7:0] w_nbr;
    nbr_count_t w_n;

    assign w_nbr = {top[CL] & L_OK, top[CC], top[CR] & R_OK,
                    mid[CL] & L_OK,          mid[CR] & R_OK,
                    bot[CL] & L_OK, bot[CC], bot[CR] & R_OK};

    // NOTE: always_comb assigns every output a default before any branch or loop, so no latch is inferred.
    always_comb begin
      w_n = '0;
      for (int i = 0; i < 8; i++) w_n = w_n + nbr_count_t'(w_nbr[i]);
    end

    assign next_row[c] = life_rule(mid[CC], w_n);
  end

endmodule

// File: rtl/generation_engine.sv
// Game-of-Life generation engine: streams rows from the current bank through a
// three-row window and writes one next-state row per cycle, then swaps banks.
// Build option: GOL_TORUS_WRAP_EN selects a toroidal grid (default: bounded, dead edges).
module generation_engine
  import gol_pkg::*;
#(
  parameter int X_SIZE  = 1280,
  parameter int Y_SIZE  = 720,
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gen_start,
  input  logic               run,
  input  logic               swap_ok,
  output logic [Y_WIDTH-1:0] line_buffer_fetch_addr,
  input  logic [X_SIZE-1:0]  line_buffer_fetch_mem,
  output logic [Y_WIDTH-1:0] parallel_next_state_write_addr,
  output logic [X_SIZE-1:0]  parallel_next_state_result,
  output logic               parallel_next_state_write_en,
  output logic               mode,
  output logic               busy,
  output logic               gen_done
);

  localparam int                 KW       = Y_WIDTH + 1;
  localparam logic [KW-1:0]      K_LAST   = KW'(Y_SIZE + 1);
  localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);

  gen_state_e         r_state, w_state_nxt;
  logic [KW-1:0]      r_k, r_rd_k, r_win_k, w_k_inc;
  logic               r_rd_v, r_win_v;
  logic [Y_WIDTH-1:0] r_fetch_addr, r_wr_addr;
  logic [X_SIZE-1:0]  r_top, r_mid, r_bot, r_result;
  logic [X_SIZE-1:0]  w_fetch_data, w_next_row;
  logic               r_wr_en, r_mode;
  logic               w_last_fetch, w_start_fetch, w_swap_fire, w_eval_v;

  assign w_last_fetch  = (r_state == ST_FETCH) && (r_k == K_LAST);
  assign w_start_fetch = (w_state_nxt == ST_FETCH) && (r_state != ST_FETCH);
  assign w_k_inc       = r_k + KW'(1);
  // Window holds fetches k-2..k once the third fetch has landed.
  assign w_eval_v      = r_win_v && (r_win_k >= KW'(2));

`ifdef GOL_TORUS_WRAP_EN
  assign w_fetch_data = line_buffer_fetch_mem;
`else
  assign w_fetch_data = ((r_rd_k == '0) || (r_rd_k == K_LAST)) ? '0 : line_buffer_fetch_mem;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_swap_fire = 1'b0;
    case (r_state)
      ST_IDLE:  if (gen_start || run) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_last_fetch) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_wr_en && (r_wr_addr == ROW_LAST)) w_state_nxt = ST_SWAP;
      ST_SWAP: begin
        if (swap_ok) begin
          w_swap_fire = 1'b1;
          w_state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_swap_fire) r_mode <= ~r_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_fetch_addr <= '0;
      r_rd_v       <= 1'b0;
      r_rd_k       <= '0;
      r_win_v      <= 1'b0;
      r_win_k      <= '0;
      r_top        <= '0;
      r_mid        <= '0;
      r_bot        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_result     <= '0;
    end else begin
      // Address sequence: Y_SIZE-1, 0, 1, ..., Y_SIZE-1, 0.
      if (w_start_fetch) begin
        r_k          <= '0;
        r_fetch_addr <= ROW_LAST;
      end else if ((r_state == ST_FETCH) && !w_last_fetch) begin
        r_k          <= w_k_inc;
        r_fetch_addr <= (w_k_inc == K_LAST) ? '0 : Y_WIDTH'(w_k_inc - KW'(1));
      end

      r_rd_v  <= (r_state == ST_FETCH);
      r_rd_k  <= r_k;
      r_win_v <= r_rd_v;
      r_win_k <= r_rd_k;

      if (r_rd_v) begin
        r_top <= r_mid;
        r_mid <= r_bot;
        r_bot <= w_fetch_data;
      end

      r_wr_en <= w_eval_v;
      if (w_eval_v) begin
        r_wr_addr <= Y_WIDTH'(r_win_k - KW'(2));
        r_result  <= w_next_row;
      end
    end
  end

  row_next_state #(
    .X_SIZE  (X_SIZE),
    .X_WIDTH (X_WIDTH)
  ) u_row_next_state (
    .top      (r_top),
    .mid      (r_mid),
    .bot      (r_bot),
    .next_row (w_next_row)
  );

  assign line_buffer_fetch_addr         = r_fetch_addr;
  assign parallel_next_state_write_addr = r_wr_addr;
  assign parallel_next_state_result     = r_result;
  assign parallel_next_state_write_en   = r_wr_en;
  assign mode                           = r_mode;
  assign busy                           = (r_state != ST_IDLE);
  assign gen_done                       = w_swap_fire;

endmodule
